// File: rtl/qram_access_arbiter.sv
// qram_access_arbiter: round-robin front end sharing one QRAM macro between
// two requesters. Each access is sequenced as ACT, RD/WR, then PRE, and a
// periodic REF is inserted.
// Ports:
//   Clock, Reset        - single clock, synchronous active-high reset
//   ReqValid/ReqWrite   - per-requester request and direction
//   ReqAddr/ReqWData    - per-requester address and write data
//   ReqAck              - one-cycle accept pulse, one-hot
//   RespValid/RespData  - one-cycle read return, one-hot
//   Busy                - sequencer active or read data still in flight
//   QramCmd/QramAddr    - command and address to the macro
//   QramWData/WriteEn   - write data and strobe, valid only in the WR cycle
//   QramClkEn           - gates the macro's DDR clock pair
//   QramRData           - read data from the macro
module qram_access_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int T_RCD     = 2,
  parameter int T_RP      = 2,
  parameter int T_RFC     = 4,
  parameter int READ_LAT  = 2,
  parameter int T_REF_INT = 64
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [1:0]          ReqValid,
  input  logic [1:0]          ReqWrite,
  input  logic [2*ADDR_W-1:0] ReqAddr,
  input  logic [2*DATA_W-1:0] ReqWData,
  output logic [1:0]          ReqAck,
  output logic [1:0]          RespValid,
  output logic [DATA_W-1:0]   RespData,
  output logic                Busy,
  output logic [2:0]          QramCmd,
  output logic [ADDR_W-1:0]   QramAddr,
  output logic [DATA_W-1:0]   QramWData,
  output logic                QramWriteEn,
  output logic                QramClkEn,
  input  logic [DATA_W-1:0]   QramRData
);

  localparam logic [2:0] CMD_NOP = 3'b000;
  localparam logic [2:0] CMD_ACT = 3'b001;
  localparam logic [2:0] CMD_RD  = 3'b010;
  localparam logic [2:0] CMD_WR  = 3'b011;
  localparam logic [2:0] CMD_PRE = 3'b100;
  localparam logic [2:0] CMD_REF = 3'b101;

  localparam int WMAX =
    (T_RCD > T_RP) ?
      ((T_RCD > T_RFC) ? T_RCD : T_RFC) :
      ((T_RP > T_RFC) ? T_RP : T_RFC);
  localparam int WAIT_W = $clog2(WMAX + 1);
  localparam int REF_W  = $clog2(T_REF_INT);

  // Wait states last T_x-1 cycles, so the counter loads T_x-2
  // and leaves on zero.
  localparam logic [WAIT_W-1:0] RCD_LOAD =
    WAIT_W'(T_RCD > 1 ? T_RCD - 2 : 0);
  localparam logic [WAIT_W-1:0] RP_LOAD =
    WAIT_W'(T_RP > 1 ? T_RP - 2 : 0);
  localparam logic [WAIT_W-1:0] RFC_LOAD =
    WAIT_W'(T_RFC > 1 ? T_RFC - 2 : 0);
  localparam logic [REF_W-1:0] REF_LOAD =
    REF_W'(T_REF_INT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACT,
    S_RCD_WAIT,
    S_RW,
    S_PRE,
    S_RP_WAIT,
    S_REF,
    S_RFC_WAIT
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [REF_W-1:0]    rcnt_q, rcnt_d;
  logic                pend_q, pend_d;
  logic [READ_LAT-1:0] rv_q, rv_d;
  logic [READ_LAT-1:0] rid_q, rid_d;

  logic [2:0]          cmd_q, cmd_d;
  logic [1:0]          ack_q, ack_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   qwd_q, qwd_d;
  logic                clken_q, clken_d;
  logic                busy_q, busy_d;
  logic [1:0]          rvld_q, rvld_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                sel;
  logic                ref_zero;
  logic                ref_due;
  logic                ref_go;
  logic                push;

  // Both valid: the one not served last; otherwise whichever is valid.
  assign sel = (&ReqValid) ? ~last_q : ReqValid[1];

  // A refresh falling due this cycle already outranks a request.
  assign ref_zero = (rcnt_q == '0);
  assign ref_due  = pend_q | ref_zero;
  assign ref_go   = (state_q == S_IDLE) & ref_due;

  assign push = (state_q == S_RW) & ~wr_q;

  always_comb begin
    rcnt_d = ref_zero ? REF_LOAD : rcnt_q - REF_W'(1);
    pend_d = ref_due & ~ref_go;
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (ref_due) begin
          state_d = S_REF;
        end else if (|ReqValid) begin
          state_d = S_ACT;
          last_d  = sel;
          addr_d  = ReqAddr[sel*ADDR_W +: ADDR_W];
          wr_d    = ReqWrite[sel];
          wdata_d = ReqWData[sel*DATA_W +: DATA_W];
        end
      end
      S_ACT: begin
        if (T_RCD == 1) begin
          state_d = S_RW;
        end else begin
          state_d = S_RCD_WAIT;
          wcnt_d  = RCD_LOAD;
        end
      end
      S_RCD_WAIT: begin
        if (wcnt_q == '0) state_d = S_RW;
        else wcnt_d = wcnt_q - WAIT_W'(1);
      end
      S_RW: begin
        state_d = S_PRE;
      end
      S_PRE: begin
        if (T_RP == 1) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RP_WAIT;
          wcnt_d  = RP_LOAD;
        end
      end
      S_RP_WAIT: begin
        if (wcnt_q == '0) state_d = S_IDLE;
        else wcnt_d = wcnt_q - WAIT_W'(1);
      end
      S_REF: begin
        if (T_RFC == 1) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RFC_WAIT;
          wcnt_d  = RFC_LOAD;
        end
      end
      S_RFC_WAIT: begin
        if (wcnt_q == '0) state_d = S_IDLE;
        else wcnt_d = wcnt_q - WAIT_W'(1);
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Read return pipe: one valid/ID slot per cycle of latency,
  // running on its own so PRE/IDLE can overlap the data return.
  always_comb begin
    rv_d     = '0;
    rid_d    = '0;
    rv_d[0]  = push;
    rid_d[0] = last_q;
    for (int k = 1; k < READ_LAT; k++) begin
      rv_d[k]  = rv_q[k-1];
      rid_d[k] = rid_q[k-1];
    end
  end

  always_comb begin
    rvld_d  = '0;
    rdata_d = rdata_q;
    if (rv_q[READ_LAT-1]) begin
      rvld_d[rid_q[READ_LAT-1]] = 1'b1;
      rdata_d = QramRData;
    end
  end

  // Outputs are decoded from the next state so they register
  // alongside it.
  always_comb begin
    cmd_d = CMD_NOP;
    unique case (state_d)
      S_ACT:   cmd_d = CMD_ACT;
      S_RW:    cmd_d = wr_d ? CMD_WR : CMD_RD;
      S_PRE:   cmd_d = CMD_PRE;
      S_REF:   cmd_d = CMD_REF;
      default: cmd_d = CMD_NOP;
    endcase
    ack_d = '0;
    if (state_d == S_ACT) ack_d[last_d] = 1'b1;
    we_d  = (state_d == S_RW) & wr_d;
    qwd_d = we_d ? wdata_d : '0;
    // The response cycle keeps the clock alive too.
    clken_d = (state_d != S_IDLE) | (|rv_d) | (|rvld_d);
    busy_d  = clken_d;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rcnt_q  <= REF_LOAD;
      pend_q  <= 1'b0;
      rv_q    <= '0;
      rid_q   <= '0;
      cmd_q   <= CMD_NOP;
      ack_q   <= '0;
      we_q    <= 1'b0;
      qwd_q   <= '0;
      clken_q <= 1'b0;
      busy_q  <= 1'b0;
      rvld_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      rcnt_q  <= rcnt_d;
      pend_q  <= pend_d;
      rv_q    <= rv_d;
      rid_q   <= rid_d;
      cmd_q   <= cmd_d;
      ack_q   <= ack_d;
      we_q    <= we_d;
      qwd_q   <= qwd_d;
      clken_q <= clken_d;
      busy_q  <= busy_d;
      rvld_q  <= rvld_d;
      rdata_q <= rdata_d;
    end
  end

  assign ReqAck      = ack_q;
  assign RespValid   = rvld_q;
  assign RespData    = rdata_q;
  assign Busy        = busy_q;
  assign QramCmd     = cmd_q;
  assign QramAddr    = addr_q;
  assign QramWData   = qwd_q;
  assign QramWriteEn = we_q;
  assign QramClkEn   = clken_q;

endmodule

// File: tb/tb_qram_access_arbiter.sv
// Bench for qram_access_arbiter: directed phases plus random traffic,
// compared cycle by cycle against a transaction-level schedule model.
module tb_qram_access_arbiter;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int T_RCD = 2;
  localparam int T_RP  = 2;
  localparam int T_RFC = 4;
  localparam int RL    = 2;
  localparam int T_REF = 64;
  localparam int N     = 4096;

  localparam logic [2:0] C_NOP = 3'd0;
  localparam logic [2:0] C_ACT = 3'd1;
  localparam logic [2:0] C_RD  = 3'd2;
  localparam logic [2:0] C_WR  = 3'd3;
  localparam logic [2:0] C_PRE = 3'd4;
  localparam logic [2:0] C_REF = 3'd5;

  logic          clk = 1'b0;
  logic          Reset;
  logic [1:0]    ReqValid, ReqWrite, ReqAck, RespValid;
  logic [2*AW-1:0] ReqAddr;
  logic [2*DW-1:0] ReqWData;
  logic [DW-1:0] RespData, QramWData, QramRData;
  logic [AW-1:0] QramAddr;
  logic [2:0]    QramCmd;
  logic          Busy, QramWriteEn, QramClkEn;

  qram_access_arbiter dut (
    .Clock(clk), .Reset(Reset),
    .ReqValid(ReqValid), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqWData(ReqWData),
    .ReqAck(ReqAck), .RespValid(RespValid),
    .RespData(RespData), .Busy(Busy),
    .QramCmd(QramCmd), .QramAddr(QramAddr),
    .QramWData(QramWData), .QramWriteEn(QramWriteEn),
    .QramClkEn(QramClkEn), .QramRData(QramRData)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [2:0] exp_cmd[N];
  logic [1:0] exp_ack[N];
  logic [1:0] exp_resp[N];
  logic [7:0] exp_rdata[N];
  logic [7:0] exp_wdata[N];
  logic [7:0] exp_addr[N];
  logic [7:0] rd_drv[N];
  bit         exp_we[N];
  bit         exp_aen[N];
  bit         exp_clk[N];
  bit         rd_en[N];
  logic [7:0] mem[256];

  bit         pend[2];
  bit         rwr[2];
  logic [7:0] rad[2];
  logic [7:0] rwd[2];
  int         gcyc[2];
  bit         auto_req, contend, want_reset;

  int         free_at, m_tick, reset_at, first_ref;
  bit         m_pend, m_last;
  logic [7:0] last_rdata;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic req(input int i, input bit w,
                     input logic [7:0] a, input logic [7:0] d);
    pend[i] = 1'b1;
    rwr[i]  = w;
    rad[i]  = a;
    rwd[i]  = d;
    gcyc[i] = -1;
  endtask

  task automatic clear_from(input int lo);
    for (int k = lo; k < N; k++) begin
      exp_cmd[k] = C_NOP; exp_ack[k] = '0; exp_resp[k] = '0;
      exp_rdata[k] = '0; exp_wdata[k] = '0; exp_addr[k] = '0;
      exp_we[k] = 0; exp_aen[k] = 0; exp_clk[k] = 0;
      rd_en[k] = 0; rd_drv[k] = '0;
    end
  endtask

  task automatic mark(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) exp_clk[k] = 1;
  endtask

  // Schedule model: decides what the arbiter does with the inputs
  // of cycle t and writes the resulting outputs into later slots.
  task automatic m_step(input int t);
    int g, a, rw, s;
    if (want_reset) begin
      clear_from(t + 1);
      free_at  = t + 1;
      m_pend   = 0;
      m_last   = 1;
      m_tick   = t + T_REF;
      reset_at = t;
      return;
    end
    if (t == m_tick) begin
      m_pend = 1;
      m_tick = m_tick + T_REF;
    end
    if (t >= free_at && t + 20 < N) begin
      if (m_pend) begin
        m_pend = 0;
        exp_cmd[t+1] = C_REF;
        mark(t + 1, t + T_RFC);
        free_at = t + 1 + T_RFC;
      end else if (pend[0] || pend[1]) begin
        g = (pend[0] && pend[1]) ? int'(!m_last) : (pend[1] ? 1 : 0);
        m_last  = g[0];
        gcyc[g] = t;
        a  = t + 1;
        rw = a + T_RCD;
        exp_cmd[a] = C_ACT;
        exp_ack[a] = g[0] ? 2'b10 : 2'b01;
        exp_cmd[rw] = rwr[g] ? C_WR : C_RD;
        exp_cmd[rw+1] = C_PRE;
        for (int k = a; k <= rw + 1; k++) begin
          exp_aen[k]  = 1;
          exp_addr[k] = rad[g];
        end
        free_at = rw + 1 + T_RP;
        mark(a, free_at - 1);
        if (rwr[g]) begin
          exp_we[rw]    = 1;
          exp_wdata[rw] = rwd[g];
          mem[rad[g]]   = rwd[g];
        end else begin
          s = rw + RL;
          rd_en[s]  = 1;
          rd_drv[s] = mem[rad[g]];
          exp_resp[s+1]  = g[0] ? 2'b10 : 2'b01;
          exp_rdata[s+1] = mem[rad[g]];
          mark(rw + 1, s + 1);
        end
      end
    end
  endtask

  task automatic check_cycle(input int c);
    chk("cmd", 32'(QramCmd), 32'(exp_cmd[c]));
    chk("ack", 32'(ReqAck), 32'(exp_ack[c]));
    chk("resp_valid", 32'(RespValid), 32'(exp_resp[c]));
    if (exp_resp[c] != 2'b00)
      chk("resp_data", 32'(RespData), 32'(exp_rdata[c]));
    chk("write_en", 32'(QramWriteEn), 32'(exp_we[c]));
    if (exp_we[c])
      chk("wdata", 32'(QramWData), 32'(exp_wdata[c]));
    if (exp_aen[c])
      chk("addr", 32'(QramAddr), 32'(exp_addr[c]));
    chk("clk_en", 32'(QramClkEn), 32'(exp_clk[c]));
    chk("busy", 32'(Busy), 32'(exp_clk[c]));
    if (c == reset_at + 1) begin
      chk("rst_addr", 32'(QramAddr), 32'd0);
      chk("rst_rdata", 32'(RespData), 32'd0);
      chk("rst_wdata", 32'(QramWData), 32'd0);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle(cyc);
    if (QramCmd === C_REF && first_ref < 0) first_ref = cyc;
    if (RespValid !== 2'b00) last_rdata = RespData;
    for (int i = 0; i < 2; i++) begin
      if (pend[i] && gcyc[i] >= 0 && cyc > gcyc[i] + 1) begin
        pend[i] = 0;
        gcyc[i] = -1;
      end
      if (!pend[i] &&
          (contend || (auto_req && $urandom_range(0, 2) == 0)))
        req(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
            8'($urandom));
    end
    Reset     = want_reset;
    ReqValid  = {pend[1], pend[0]};
    ReqWrite  = {rwr[1], rwr[0]};
    ReqAddr   = {rad[1], rad[0]};
    ReqWData  = {rwd[1], rwd[0]};
    QramRData = rd_en[cyc] ? rd_drv[cyc] : 8'($urandom);
    m_step(cyc);
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    Reset = 1'b1;
    ReqValid = '0; ReqWrite = '0; ReqAddr = '0; ReqWData = '0;
    QramRData = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h3C] = 8'hA5;
    clear_from(0);
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; rwr[i] = 0; rad[i] = '0; rwd[i] = '0; gcyc[i] = -1;
    end
    auto_req = 0; contend = 0;
    reset_at = -100; first_ref = -1; free_at = 0;
    m_tick = 1 << 30; m_pend = 0; m_last = 1;
    last_rdata = '0;

    want_reset = 1; step(); want_reset = 0;
    repeat (70) step();
    chk("first_ref_cycle", 32'(first_ref), 32'(T_REF + 1));

    req(0, 0, 8'h3C, 8'h00); repeat (10) step();
    chk("single_read_data", 32'(last_rdata), 32'h A5);

    req(1, 1, 8'h10, 8'h5A); repeat (10) step();
    req(0, 0, 8'h10, 8'h00); repeat (10) step();
    chk("readback_data", 32'(last_rdata), 32'h5A);

    contend = 1; repeat (30) step();
    contend = 0; repeat (10) step();

    while (cyc < m_tick) step();
    req(1, 0, 8'h3C, 8'h00); repeat (15) step();

    req(0, 0, 8'h22, 8'h00);
    repeat (4) step();
    want_reset = 1; step(); want_reset = 0;
    repeat (12) step();

    auto_req = 1;
    repeat (2000) begin
      if ($urandom_range(0, 599) == 0) want_reset = 1;
      step();
      want_reset = 0;
    end
    auto_req = 0;
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
